// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared FSM encoding and constants for the uart_tx round-robin arbiter.
// Revision 1.0
`default_nettype none

package uart_arb_pkg;

  localparam int         CH_W       = 4;
  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder; searches from ptr+1 upward, wrapping.
// Revision 1.0
`default_nettype none

module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [CH_W-1:0]  ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [CH_W-1:0]  idx,
  output logic             any
);

  logic [N_REQ-1:0] hi;

  always_comb begin
    hi     = '0;
    onehot = '0;
    idx    = '0;
    any    = |req;
    for (int k = 0; k < N_REQ; k++) begin
      hi[k] = req[k] && (k > int'(ptr));
    end
    // Lowest requester above the pointer wins; otherwise wrap to the lowest overall.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hi[k] || (!(|hi) && req[k])) idx = CH_W'(k);
    end
    for (int k = 0; k < N_REQ; k++) begin
      onehot[k] = any && (idx == CH_W'(k));
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N_REQ byte requesters.
// Optional per-burst channel header frame enabled by UART_TX_ARB_HDR_EN. Revision 1.0
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 1,
  parameter int GAP_CYCLES = 2,
  parameter int BUSY_TMO   = 8
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_busy_i,
  output logic               busy_o,
  output logic [3:0]         cur_ch_o,
  output logic               err_o
);

  localparam logic [15:0] TMO_LIM  = 16'(BUSY_TMO - 2);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [7:0]  BURST_MX = 8'(MAX_BURST);

  arb_state_t       state;
  logic [CH_W-1:0]  ptr;
  logic [7:0]       burst;
  logic [7:0]       gap_cnt;
  logic [15:0]      tmo_cnt;

  logic [N_REQ-1:0] w_pick_oh;
  logic [CH_W-1:0]  w_pick_idx;
  logic             w_pick_any;
  logic [7:0]       w_pick_byte;
  logic [N_REQ-1:0] w_cur_oh;
  logic             w_cur_req;
  logic [7:0]       w_cur_byte;
  logic             w_gap_done;
  logic             w_continue;

`ifdef UART_TX_ARB_HDR_EN
  logic             hdr_phase;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (req_i),
    .ptr    (ptr),
    .onehot (w_pick_oh),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  always_comb begin
    w_pick_byte = '0;
    w_cur_byte  = '0;
    w_cur_oh    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_pick_idx == CH_W'(k)) w_pick_byte = data_i[8*k +: 8];
      if (cur_ch_o == CH_W'(k)) begin
        w_cur_byte  = data_i[8*k +: 8];
        w_cur_oh[k] = 1'b1;
      end
    end
    w_cur_req  = |(req_i & w_cur_oh);
    w_gap_done = ((state == ST_WAIT_DONE) && !tx_busy_i && (GAP_CYCLES == 0)) ||
                 ((state == ST_GAP) && (gap_cnt == GAP_LAST));
`ifdef UART_TX_ARB_HDR_EN
    // After a header the first data byte is always fetched, independent of burst count.
    w_continue = w_cur_req && (hdr_phase || (burst < BURST_MX));
`else
    w_continue = w_cur_req && (burst < BURST_MX);
`endif
  end

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state      <= ST_IDLE;
      ptr        <= CH_W'(N_REQ - 1);
      burst      <= '0;
      gap_cnt    <= '0;
      tmo_cnt    <= '0;
      gnt_o      <= '0;
      tx_data_o  <= '0;
      tx_start_o <= 1'b0;
      cur_ch_o   <= '0;
      err_o      <= 1'b0;
`ifdef UART_TX_ARB_HDR_EN
      hdr_phase  <= 1'b0;
`endif
    end else begin
      gnt_o      <= '0;
      tx_start_o <= 1'b0;
      err_o      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (w_pick_any) begin
            ptr      <= w_pick_idx;
            cur_ch_o <= w_pick_idx;
            burst    <= 8'd1;
            state    <= ST_ARM;
`ifdef UART_TX_ARB_HDR_EN
            tx_data_o <= {HDR_NIBBLE, w_pick_idx};
            hdr_phase <= 1'b1;
`else
            tx_data_o <= w_pick_byte;
            gnt_o     <= w_pick_oh;
`endif
          end
        end
        ST_ARM: state <= ST_START;
        ST_START: begin
          tx_start_o <= 1'b1;
          tmo_cnt    <= '0;
          state      <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy_i) begin
            state <= ST_WAIT_DONE;
          end else if (tmo_cnt == TMO_LIM) begin
            err_o <= 1'b1;
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy_i && (GAP_CYCLES != 0)) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (!w_gap_done) gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= ST_IDLE;
      endcase

      // Shared end-of-gap decision; also reached straight from WAIT_DONE when there is no gap.
      if (w_gap_done) begin
        if (w_continue) begin
          tx_data_o <= w_cur_byte;
          gnt_o     <= w_cur_oh;
          state     <= ST_ARM;
`ifdef UART_TX_ARB_HDR_EN
          burst     <= hdr_phase ? 8'd1 : burst + 8'd1;
          hdr_phase <= 1'b0;
`else
          burst     <= burst + 8'd1;
`endif
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

`default_nettype wire
